// File: rtl/alu_issue_stage.sv
// ALU issue stage: skid buffer -> S1 operand register -> external ALU -> S2 result register.
// Valid/ready on both sides, one op per cycle, full backpressure, synchronous flush.
// in_ready comes straight from a flop; the skid entry absorbs the one op that can be
// accepted while S1 is stalled.

module alu_issue_stage #(
   parameter int NBITS = 8,
   parameter int OPW   = 4,
   parameter int TAGW  = 5,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   in_op,
   input  logic [NBITS-1:0] in_a,
   input  logic [NBITS-1:0] in_b,
   input  logic [TAGW-1:0]  in_tag,
   output logic [OPW-1:0]   alu_op,
   output logic [NBITS-1:0] alu_a,
   output logic [NBITS-1:0] alu_b,
   input  logic [NBITS-1:0] alu_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NBITS-1:0] out_res,
   output logic [TAGW-1:0]  out_tag,
   output logic             out_zero,
   output logic [CNTW-1:0]  ops_done
);

   // skid entry
   logic             skid_valid;
   logic [OPW-1:0]   skid_op;
   logic [NBITS-1:0] skid_a;
   logic [NBITS-1:0] skid_b;
   logic [TAGW-1:0]  skid_tag;

   // S1 operand register (op/a/b drive the ALU directly)
   logic             s1_valid;
   logic [OPW-1:0]   s1_op;
   logic [NBITS-1:0] s1_a;
   logic [NBITS-1:0] s1_b;
   logic [TAGW-1:0]  s1_tag;

   // S2 result register
   logic             s2_valid;
   logic [NBITS-1:0] s2_res;
   logic [TAGW-1:0]  s2_tag;
   logic             s2_zero;

   logic             in_ready_q;
   logic [CNTW-1:0]  ops_done_q;

   // control terms
   logic s2_en;
   logic s1_en;
   logic acc;
   logic out_hs;
   logic s1_from_skid;
   logic s1_from_in;
   logic skid_load;
   logic skid_valid_nxt;
   logic s1_valid_nxt;
   logic s2_valid_nxt;

   // Advance/load decisions for all three registers; flush overrides every valid update.
   always_comb begin
      s2_en        = !s2_valid || out_ready;
      s1_en        = !s1_valid || s2_en;
      acc          = in_valid && in_ready_q;
      out_hs       = s2_valid && out_ready;
      s1_from_skid = s1_en && skid_valid;
      s1_from_in   = s1_en && !skid_valid && acc;
      // acc with skid_valid is unreachable (in_ready is low then) but is kept in the
      // load term so the skid never drops an input if that invariant were broken.
      skid_load    = acc && (!s1_en || skid_valid);

      skid_valid_nxt = skid_valid;
      if (flush)
         skid_valid_nxt = 1'b0;
      else if (skid_load)
         skid_valid_nxt = 1'b1;
      else if (s1_from_skid)
         skid_valid_nxt = 1'b0;

      s1_valid_nxt = s1_valid;
      if (flush)
         s1_valid_nxt = 1'b0;
      else if (s1_en)
         s1_valid_nxt = skid_valid || acc;

      s2_valid_nxt = s2_valid;
      if (flush)
         s2_valid_nxt = 1'b0;
      else if (s2_en)
         s2_valid_nxt = s1_valid;
   end

   // Valid bits and the registered ready; ready tracks whether the skid will be empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid <= 1'b0;
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         skid_valid <= skid_valid_nxt;
         s1_valid   <= s1_valid_nxt;
         s2_valid   <= s2_valid_nxt;
         in_ready_q <= !skid_valid_nxt;
      end
   end

   // Skid payload: captures the input only when S1 cannot take it this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_op  <= '0;
         skid_a   <= '0;
         skid_b   <= '0;
         skid_tag <= '0;
      end else if (skid_load) begin
         skid_op  <= in_op;
         skid_a   <= in_a;
         skid_b   <= in_b;
         skid_tag <= in_tag;
      end
   end

   // S1 payload: the skid entry is older than the live input, so it always goes first.
   // Operands only change on a real load, keeping alu_res steady through a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_op  <= '0;
         s1_a   <= '0;
         s1_b   <= '0;
         s1_tag <= '0;
      end else if (s1_from_skid) begin
         s1_op  <= skid_op;
         s1_a   <= skid_a;
         s1_b   <= skid_b;
         s1_tag <= skid_tag;
      end else if (s1_from_in) begin
         s1_op  <= in_op;
         s1_a   <= in_a;
         s1_b   <= in_b;
         s1_tag <= in_tag;
      end
   end

   // S2 payload: capture the ALU result and its zero flag whenever S2 may advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_res  <= '0;
         s2_tag  <= '0;
         s2_zero <= 1'b0;
      end else if (s2_en) begin
         s2_res  <= alu_res;
         s2_tag  <= s1_tag;
         s2_zero <= (alu_res == '0);
      end
   end

   // Completed-op counter: counts writeback handshakes, sticks at all-ones, survives flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ops_done_q <= '0;
      else if (out_hs && !(&ops_done_q))
         ops_done_q <= ops_done_q + CNTW'(1);
   end

   assign in_ready  = in_ready_q;
   assign alu_op    = s1_op;
   assign alu_a     = s1_a;
   assign alu_b     = s1_b;
   assign out_valid = s2_valid;
   assign out_res   = s2_res;
   assign out_tag   = s2_tag;
   assign out_zero  = s2_zero;
   assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: stands in for the combinational ALU, keeps an in-order queue of
// expected results pushed at every input handshake, and checks the outputs every cycle.

module tb_alu_issue_stage;

   localparam int NBITS = 8;
   localparam int OPW   = 4;
   localparam int TAGW  = 5;
   localparam int CNTW  = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [OPW-1:0]   in_op = '0;
   logic [NBITS-1:0] in_a = '0;
   logic [NBITS-1:0] in_b = '0;
   logic [TAGW-1:0]  in_tag = '0;
   logic [OPW-1:0]   alu_op;
   logic [NBITS-1:0] alu_a;
   logic [NBITS-1:0] alu_b;
   logic [NBITS-1:0] alu_res;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [NBITS-1:0] out_res;
   logic [TAGW-1:0]  out_tag;
   logic             out_zero;
   logic [CNTW-1:0]  ops_done;

   int n_tests = 0;
   int n_fail  = 0;

   alu_issue_stage #(.NBITS(NBITS), .OPW(OPW), .TAGW(TAGW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_tag(out_tag), .out_zero(out_zero),
      .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   // ALU stand-in: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, others pass A.
   function automatic logic [NBITS-1:0] alu_ref(input logic [OPW-1:0] op,
                                                input logic [NBITS-1:0] a,
                                                input logic [NBITS-1:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[2:0];
         4'd6:    return a >> b[2:0];
         default: return a;
      endcase
   endfunction

   assign alu_res = alu_ref(alu_op, alu_a, alu_b);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: ordered queue of expected {result, tag} plus a handshake count.
   typedef struct packed {
      logic [NBITS-1:0] res;
      logic [TAGW-1:0]  tag;
   } exp_t;

   exp_t             q[$];
   int               cnt_model = 0;
   logic             stalled = 1'b0;
   logic [NBITS-1:0] held_res = '0;
   logic [TAGW-1:0]  held_tag = '0;

   // Compare process: inputs change just after posedge, so negedge sees the values the
   // next posedge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         cnt_model = 0;
         stalled   = 1'b0;
      end else begin
         chk("ops_done", 32'(ops_done), 32'(cnt_model));
         if (stalled) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_res", 32'(out_res), 32'(held_res));
            chk("hold_tag", 32'(out_tag), 32'(held_tag));
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               chk("out_res", 32'(out_res), 32'(q[0].res));
               chk("out_tag", 32'(out_tag), 32'(q[0].tag));
               chk("out_zero", 32'(out_zero), 32'(q[0].res == '0));
               if (out_ready) void'(q.pop_front());
            end
         end
         if (out_valid && out_ready && cnt_model != 65535) cnt_model++;
         if (in_valid && in_ready) q.push_back('{res: alu_ref(in_op, in_a, in_b), tag: in_tag});
         if (flush) q.delete();
         stalled  = out_valid && !out_ready && !flush;
         held_res = out_res;
         held_tag = out_tag;
      end
   end

   task automatic do_reset();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n  = 1'b1;
   endtask

   // Present one op and hold it until accepted (bounded).
   task automatic send_op(input logic [OPW-1:0] op, input logic [NBITS-1:0] a,
                          input logic [NBITS-1:0] b, input logic [TAGW-1:0] tag);
      logic took;
      took     = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      for (int i = 0; i < 50 && !took; i++) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("send_accept", 32'(took), 32'd1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, 32'(q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int issued;
      int cyc;
      logic took;

      #1;
      do_reset();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);

      // Reset mid-stream: ops flowing, then async reset mid-cycle.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_op(4'd0, 8'(i), 8'd1, 5'(i));
      out_ready = 1'b0;
      send_op(4'd4, 8'h55, 8'h0F, 5'd9);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_ops_done", 32'(ops_done), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single ADD: out_valid two edges after presentation.
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = 4'd0; in_a = 8'h05; in_b = 8'h03; in_tag = 5'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("add_lat_early", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_res", 32'(out_res), 32'h08);
      chk("add_tag", 32'(out_tag), 32'd3);
      chk("add_zero", 32'(out_zero), 32'd0);
      @(posedge clk); #1;
      chk("add_ops_done", 32'(ops_done), 32'd1);
      chk("add_gone", 32'(out_valid), 32'd0);

      // Zero result.
      in_valid = 1'b1; in_op = 4'd1; in_a = 8'h2A; in_b = 8'h2A; in_tag = 5'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("sub_valid", 32'(out_valid), 32'd1);
      chk("sub_res", 32'(out_res), 32'h00);
      chk("sub_zero", 32'(out_zero), 32'd1);
      @(posedge clk); #1;
      chk("sub_ops_done", 32'(ops_done), 32'd2);

      // Backpressure: three accepts fill S2, S1, skid; the fourth waits.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_op = 4'(i + 2); in_a = 8'hC3; in_b = 8'h5A; in_tag = 5'(10 + i);
         @(posedge clk); #1;
      end
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      in_op = 4'd0; in_a = 8'h7F; in_b = 8'h01; in_tag = 5'd13;
      @(posedge clk); #1;
      chk("bp_still_blocked", 32'(in_ready), 32'd0);
      chk("bp_head_tag", 32'(out_tag), 32'd10);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_stream_valid", 32'(out_valid), 32'd1);
         chk("bp_stream_tag", 32'(out_tag), 32'(10 + i));
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took) in_valid = 1'b0;
      end
      chk("bp_ops_done", 32'(ops_done), 32'd6);
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Flush with three ops in flight and no writeback handshake.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_op = 4'd3; in_a = 8'(i); in_b = 8'h80; in_tag = 5'(20 + i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_ops_done", 32'(ops_done), 32'd6);
      out_ready = 1'b1;
      send_op(4'd2, 8'hF0, 8'h3C, 5'd23);
      cyc = 0;
      while (!out_valid && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("post_flush_res", 32'(out_res), 32'h30);
      chk("post_flush_tag", 32'(out_tag), 32'd23);
      @(posedge clk); #1;
      chk("post_flush_ops_done", 32'(ops_done), 32'd7);

      // Random traffic: 1000 ops, random valid gaps and writeback stalls.
      do_reset();
      issued = 0;
      cyc = 0;
      while (issued < 1000 && cyc < 20000) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_op    = 4'($urandom_range(0, 8));
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            in_tag   = 5'($urandom);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (took) begin
            in_valid = 1'b0;
            issued++;
         end
      end
      in_valid = 1'b0;
      drain("rand_drain");
      chk("rand_ops_done", 32'(ops_done), 32'd1000);

      // Random traffic with occasional flush, including flush on a writeback handshake.
      for (int i = 0; i < 400; i++) begin
         if (!in_valid && $urandom_range(0, 2) != 0) begin
            in_valid = 1'b1;
            in_op    = 4'($urandom_range(0, 8));
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            in_tag   = 5'($urandom);
         end
         out_ready = ($urandom_range(0, 1) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took || flush) in_valid = 1'b0;
      end
      flush = 1'b0;
      in_valid = 1'b0;
      drain("flush_rand_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
